// File: rtl/registerfile_banked_if.sv
// Bus bundle for the banked register file: read ports, sized write port,
// scoreboard set and bulk-clear handshake.
interface registerfile_banked_if #(
    parameter int WIDTH  = 32,
    parameter int COUNTP = 4
);
    logic              supervisor;
    logic [COUNTP-1:0] read1;
    logic [COUNTP-1:0] read2;
    logic [WIDTH-1:0]  data1;
    logic [WIDTH-1:0]  data2;
    logic              busy1;
    logic              busy2;
    logic [COUNTP-1:0] write_addr;
    logic [WIDTH-1:0]  write_data;
    logic [1:0]        write_en;
    logic              write_sext;
    logic              busy_set;
    logic [COUNTP-1:0] busy_addr;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;

    modport master (
        output supervisor, read1, read2, write_addr, write_data, write_en,
               write_sext, busy_set, busy_addr, clear_req,
        input  data1, data2, busy1, busy2, clear_busy, clear_done
    );

    modport slave (
        input  supervisor, read1, read2, write_addr, write_data, write_en,
               write_sext, busy_set, busy_addr, clear_req,
        output data1, data2, busy1, busy2, clear_busy, clear_done
    );
endinterface

// File: rtl/registerfile_banked.sv
// General-purpose register file with supervisor-banked SP, sized writes,
// optional write-to-read bypass, pending-load scoreboard and bulk clear.
module registerfile_banked #(
    parameter int WIDTH    = 32,
    parameter int COUNT    = 16,
    parameter int COUNTP   = 4,
    parameter int SP_INDEX = 15,
    parameter int BYPASS   = 1
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    registerfile_banked_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLR, CLR_SSP} state_t;

    localparam logic [COUNTP-1:0] SP_ADDR   = COUNTP'(SP_INDEX);
    localparam logic [COUNTP-1:0] LAST_IDX  = COUNTP'(COUNT - 1);
    localparam logic [COUNTP:0]   COUNT_LIM = (COUNTP + 1)'(COUNT);

    state_t            state_reg;
    logic [COUNTP-1:0] idx_reg;
    logic              clear_busy_reg;
    logic              clear_done_reg;
    logic [WIDTH-1:0]  regs_reg [COUNT];
    logic [WIDTH-1:0]  ssp_reg;
    logic [COUNT-1:0]  busy_reg;
    logic              ssp_busy_reg;

    logic              idle;
    logic              wr_active;
    logic              wr_ssp;
    logic              wr_in_range;
    logic              set_active;
    logic              set_ssp;
    logic              clear_start;
    logic [WIDTH-1:0]  wr_data_formed;
    logic [COUNT-1:0]  wr_hit;
    logic [COUNT-1:0]  set_hit;

    // Writes and busy_set are only honoured while the clear sequencer is idle
    assign idle        = (state_reg == IDLE);
    assign wr_active   = idle && (bus.write_en != 2'b00);
    assign wr_ssp      = bus.supervisor && (bus.write_addr == SP_ADDR);
    assign wr_in_range = ({1'b0, bus.write_addr} < COUNT_LIM);
    assign set_active  = idle && bus.busy_set;
    assign set_ssp     = bus.supervisor && (bus.busy_addr == SP_ADDR);
    assign clear_start = idle && bus.clear_req;

    always_comb begin
        case (bus.write_en)
            2'b01:   wr_data_formed = {{(WIDTH-8){bus.write_sext & bus.write_data[7]}},
                                       bus.write_data[7:0]};
            2'b10:   wr_data_formed = {{(WIDTH-16){bus.write_sext & bus.write_data[15]}},
                                       bus.write_data[15:0]};
            default: wr_data_formed = bus.write_data;
        endcase
    end

    generate
        for (genvar gi = 0; gi < COUNT; gi++) begin : g_hit
            assign wr_hit[gi]  = wr_active && !wr_ssp && (bus.write_addr == COUNTP'(gi));
            assign set_hit[gi] = set_active && !set_ssp && (bus.busy_addr == COUNTP'(gi));
        end

        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [COUNTP-1:0] addr;
            logic [WIDTH-1:0]  data_c;
            logic              busy_c;
            logic              rd_ssp;
            logic              rd_in_range;
            logic              bypass_hit;

            assign addr        = (gi == 0) ? bus.read1 : bus.read2;
            assign rd_ssp      = bus.supervisor && (addr == SP_ADDR);
            assign rd_in_range = ({1'b0, addr} < COUNT_LIM);
            assign bypass_hit  = (BYPASS != 0) && wr_active &&
                                 (rd_ssp ? wr_ssp
                                         : (!wr_ssp && wr_in_range && (addr == bus.write_addr)));

            always_comb begin
                data_c = '0;
                busy_c = 1'b0;
                if (rd_ssp) begin
                    data_c = ssp_reg;
                    busy_c = ssp_busy_reg;
                end else if (rd_in_range) begin
                    data_c = regs_reg[addr];
                    busy_c = busy_reg[addr];
                end
                if (bypass_hit) begin
                    data_c = wr_data_formed;
                end
            end

            if (gi == 0) begin : g_p1
                assign bus.data1 = data_c;
                assign bus.busy1 = busy_c;
            end else begin : g_p2
                assign bus.data2 = data_c;
                assign bus.busy2 = busy_c;
            end
        end
    endgenerate

    assign bus.clear_busy = clear_busy_reg;
    assign bus.clear_done = clear_done_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            clear_busy_reg <= 1'b0;
            clear_done_reg <= 1'b0;
            ssp_reg        <= '0;
            ssp_busy_reg   <= 1'b0;
            busy_reg       <= '0;
            for (int i = 0; i < COUNT; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            clear_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.clear_req) begin
                        state_reg      <= CLR;
                        idx_reg        <= '0;
                        clear_busy_reg <= 1'b1;
                    end
                end
                CLR: begin
                    regs_reg[idx_reg] <= '0;
                    if (idx_reg == LAST_IDX) begin
                        state_reg      <= CLR_SSP;
                        clear_done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + COUNTP'(1);
                    end
                end
                CLR_SSP: begin
                    ssp_reg        <= '0;
                    state_reg      <= IDLE;
                    clear_busy_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase

            if (wr_active && wr_ssp) begin
                ssp_reg <= wr_data_formed;
            end
            for (int i = 0; i < COUNT; i++) begin
                if (wr_hit[i]) begin
                    regs_reg[i] <= wr_data_formed;
                end
            end

            // Precedence: starting a clear wipes everything, then set beats write-clear
            if (clear_start) begin
                ssp_busy_reg <= 1'b0;
            end else if (set_active && set_ssp) begin
                ssp_busy_reg <= 1'b1;
            end else if (wr_active && wr_ssp) begin
                ssp_busy_reg <= 1'b0;
            end
            for (int i = 0; i < COUNT; i++) begin
                if (clear_start) begin
                    busy_reg[i] <= 1'b0;
                end else if (set_hit[i]) begin
                    busy_reg[i] <= 1'b1;
                end else if (wr_hit[i]) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_registerfile_banked.sv
// Scoreboard bench for registerfile_banked: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_registerfile_banked;
    localparam int SIG_DATA1 = 0;
    localparam int SIG_DATA2 = 1;
    localparam int SIG_BUSY1 = 2;
    localparam int SIG_BUSY2 = 3;
    localparam int SIG_CBUSY = 4;
    localparam int SIG_CDONE = 5;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp_val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [31:0] mon_act;

    registerfile_banked_if #(.WIDTH(32), .COUNTP(4)) bus ();

    registerfile_banked #(
        .WIDTH(32), .COUNT(16), .COUNTP(4), .SP_INDEX(15), .BYPASS(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string n, input int s, input logic [31:0] e);
        q.push_back('{name: n, sig: s, exp_val: e});
    endtask

    task automatic wr(input logic sup, input logic [3:0] a, input logic [31:0] d,
                      input logic [1:0] en, input logic sx);
        bus.supervisor = sup;
        bus.write_addr = a;
        bus.write_data = d;
        bus.write_en   = en;
        bus.write_sext = sx;
    endtask

    // Monitor: outputs are combinational/registered, sampled mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            case (mon_e.sig)
                SIG_DATA1: mon_act = bus.data1;
                SIG_DATA2: mon_act = bus.data2;
                SIG_BUSY1: mon_act = {31'b0, bus.busy1};
                SIG_BUSY2: mon_act = {31'b0, bus.busy2};
                SIG_CBUSY: mon_act = {31'b0, bus.clear_busy};
                default:   mon_act = {31'b0, bus.clear_done};
            endcase
            checks++;
            if (mon_act !== mon_e.exp_val) begin
                errors++;
                $display("FAIL %s got %h expected %h", mon_e.name, mon_act, mon_e.exp_val);
            end else begin
                $display("check %s = %h ok", mon_e.name, mon_act);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        bus.supervisor = 1'b0;
        bus.read1      = '0;
        bus.read2      = '0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.write_en   = 2'b00;
        bus.write_sext = 1'b0;
        bus.busy_set   = 1'b0;
        bus.busy_addr  = '0;
        bus.clear_req  = 1'b0;
        repeat (2) cyc();

        // Reset state
        bus.read1 = 4'd3;
        bus.read2 = 4'd15;
        expect_v("rst_data1", SIG_DATA1, 32'h0);
        expect_v("rst_data2", SIG_DATA2, 32'h0);
        expect_v("rst_busy1", SIG_BUSY1, 32'h0);
        expect_v("rst_clear_busy", SIG_CBUSY, 32'h0);
        expect_v("rst_clear_done", SIG_CDONE, 32'h0);
        cyc();
        rst_n = 1'b1;

        // Word write with same-cycle bypass, then registered readback
        wr(1'b0, 4'd3, 32'hDEADBEEF, 2'b11, 1'b0);
        bus.read1 = 4'd3;
        bus.read2 = 4'd4;
        expect_v("bypass_word_r3", SIG_DATA1, 32'hDEADBEEF);
        expect_v("unrelated_r4", SIG_DATA2, 32'h0);
        cyc();
        bus.write_en = 2'b00;
        expect_v("readback_r3", SIG_DATA1, 32'hDEADBEEF);
        cyc();

        // Sized writes with sign/zero extension
        wr(1'b0, 4'd2, 32'h000000F0, 2'b01, 1'b1);
        bus.read2 = 4'd2;
        expect_v("bypass_byte_sext", SIG_DATA2, 32'hFFFFFFF0);
        cyc();
        bus.write_en = 2'b00;
        bus.read1    = 4'd2;
        expect_v("byte_sext_r2", SIG_DATA1, 32'hFFFFFFF0);
        cyc();
        wr(1'b0, 4'd2, 32'hABCD12F0, 2'b01, 1'b0);
        cyc();
        bus.write_en = 2'b00;
        expect_v("byte_zext_r2", SIG_DATA1, 32'h000000F0);
        cyc();
        wr(1'b0, 4'd2, 32'h00008001, 2'b10, 1'b1);
        cyc();
        bus.write_en = 2'b00;
        expect_v("half_sext_r2", SIG_DATA1, 32'hFFFF8001);
        cyc();

        // Banked stack pointer
        wr(1'b1, 4'd15, 32'h00001000, 2'b11, 1'b0);
        cyc();
        wr(1'b0, 4'd15, 32'h00002000, 2'b11, 1'b0);
        cyc();
        bus.write_en   = 2'b00;
        bus.supervisor = 1'b1;
        bus.read1      = 4'd15;
        expect_v("ssp_read", SIG_DATA1, 32'h00001000);
        cyc();
        bus.supervisor = 1'b0;
        expect_v("r15_read", SIG_DATA1, 32'h00002000);
        cyc();

        // Scoreboard
        bus.busy_set  = 1'b1;
        bus.busy_addr = 4'd5;
        bus.read1     = 4'd5;
        expect_v("busy_before_set", SIG_BUSY1, 32'h0);
        cyc();
        bus.busy_set = 1'b0;
        expect_v("busy_after_set", SIG_BUSY1, 32'h1);
        cyc();
        bus.busy_set = 1'b1;
        wr(1'b0, 4'd5, 32'h00000055, 2'b11, 1'b0);
        cyc();
        bus.busy_set = 1'b0;
        bus.write_en = 2'b00;
        expect_v("busy_set_wins", SIG_BUSY1, 32'h1);
        cyc();
        wr(1'b0, 4'd5, 32'h00000066, 2'b11, 1'b0);
        expect_v("busy_no_bypass", SIG_BUSY1, 32'h1);
        cyc();
        bus.write_en = 2'b00;
        expect_v("busy_cleared_by_write", SIG_BUSY1, 32'h0);
        expect_v("r5_value", SIG_DATA1, 32'h00000066);
        cyc();

        // Fill all registers and ssp, then bulk clear
        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 4'(i), (i + 1) * 32'h01010101, 2'b11, 1'b0);
            cyc();
        end
        wr(1'b1, 4'd15, 32'hABCD0000, 2'b11, 1'b0);
        cyc();
        bus.write_en   = 2'b00;
        bus.supervisor = 1'b0;
        bus.busy_set   = 1'b1;
        bus.busy_addr  = 4'd7;
        cyc();
        bus.busy_set   = 1'b0;
        bus.supervisor = 1'b1;
        bus.read1      = 4'd15;
        bus.read2      = 4'd7;
        expect_v("fill_ssp", SIG_DATA1, 32'hABCD0000);
        expect_v("fill_busy_r7", SIG_BUSY2, 32'h1);
        expect_v("fill_r7", SIG_DATA2, 32'h08080808);
        cyc();
        bus.supervisor = 1'b0;
        bus.clear_req  = 1'b1;
        expect_v("clear_idle_busy", SIG_CBUSY, 32'h0);
        cyc();
        bus.clear_req = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            expect_v($sformatf("clear_busy_c%0d", k), SIG_CBUSY, 32'h1);
            expect_v($sformatf("clear_done_c%0d", k), SIG_CDONE, (k == 17) ? 32'h1 : 32'h0);
            if (k == 3) begin
                wr(1'b0, 4'd0, 32'h00000777, 2'b11, 1'b0);
                bus.read1 = 4'd0;
                bus.read2 = 4'd10;
                expect_v("mid_clear_no_bypass_r0", SIG_DATA1, 32'h0);
                expect_v("mid_clear_r10_intact", SIG_DATA2, 32'h0B0B0B0B);
            end
            if (k == 4) begin
                bus.write_en  = 2'b00;
                bus.busy_set  = 1'b1;
                bus.busy_addr = 4'd9;
            end
            if (k == 5) begin
                bus.busy_set = 1'b0;
            end
            cyc();
        end
        expect_v("post_clear_busy", SIG_CBUSY, 32'h0);
        expect_v("post_clear_done", SIG_CDONE, 32'h0);
        for (int i = 0; i < 16; i++) begin
            bus.read1 = 4'(i);
            bus.read2 = 4'(i);
            expect_v($sformatf("cleared_r%0d", i), SIG_DATA1, 32'h0);
            expect_v($sformatf("cleared_busy_r%0d", i), SIG_BUSY2, 32'h0);
            cyc();
        end
        bus.supervisor = 1'b1;
        bus.read1      = 4'd15;
        expect_v("cleared_ssp", SIG_DATA1, 32'h0);
        cyc();

        // Reset in the middle of a clear
        wr(1'b0, 4'd12, 32'h0000CCCC, 2'b11, 1'b0);
        cyc();
        wr(1'b1, 4'd15, 32'h00005555, 2'b11, 1'b0);
        cyc();
        bus.write_en   = 2'b00;
        bus.supervisor = 1'b0;
        bus.clear_req  = 1'b1;
        cyc();
        bus.clear_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_v($sformatf("abort_clear_busy_c%0d", k), SIG_CBUSY, 32'h1);
            cyc();
        end
        rst_n = 1'b0;
        expect_v("abort_clear_busy_c5", SIG_CBUSY, 32'h1);
        cyc();
        rst_n          = 1'b1;
        bus.read1      = 4'd12;
        bus.read2      = 4'd15;
        bus.supervisor = 1'b1;
        expect_v("abort_clear_busy_low", SIG_CBUSY, 32'h0);
        expect_v("abort_r12_zero", SIG_DATA1, 32'h0);
        expect_v("abort_ssp_zero", SIG_DATA2, 32'h0);
        cyc();
        bus.supervisor = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expect_v($sformatf("abort_no_done_%0d", k), SIG_CDONE, 32'h0);
            cyc();
        end

        repeat (2) cyc();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL monitor_drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
